// File: rtl/div_ctrl.sv
`timescale 1ns/1ps
// Radix-2 restoring divide sequencer for DIV/DIVU; returns {remainder, quotient}.
// Latency: WIDTH+1 cycles from accepted start to ready_o (2 cycles for divide-by-zero).
// Backpressure: stallreq_o holds the pipeline until ready_o; result held in END while start_i stays high.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BY_ZERO,
        S_ON,
        S_END
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] rem_q;
    // Dividend bits shift out of the top while quotient bits fill in from the bottom.
    logic [WIDTH-1:0] dvd_q;
    logic             neg_quot_q;
    logic             neg_rem_q;

    logic             op1_neg;
    logic             op2_neg;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             accept;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quot_nxt;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] quot_fix;

    assign stallreq_o = start_i & ~ready_o & ~annul_i;

    assign accept  = start_i & ~annul_i;
    assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign mag1    = op1_neg ? -opdata1_i : opdata1_i;
    assign mag2    = op2_neg ? -opdata2_i : opdata2_i;

    // The partial remainder is always below the divisor, so the shifted trial value
    // needs one extra bit and a borrow out of that bit means "does not fit".
    always_comb begin
        trial    = {rem_q, dvd_q[WIDTH-1]};
        diff     = trial - {1'b0, divisor_q};
        take     = ~diff[WIDTH];
        rem_nxt  = take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quot_nxt = {dvd_q[WIDTH-2:0], take};
        rem_fix  = neg_rem_q  ? -rem_nxt  : rem_nxt;
        quot_fix = neg_quot_q ? -quot_nxt : quot_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (opdata2_i == '0) ? S_BY_ZERO : S_ON;
                end
            end
            S_BY_ZERO: begin
                state_nxt = S_END;
            end
            S_ON: begin
                if (annul_i) begin
                    state_nxt = S_IDLE;
                end else if (cnt == LAST_ITER) begin
                    state_nxt = S_END;
                end
            end
            S_END: begin
                if (annul_i || !start_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_o   <= '0;
            ready_o    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (accept) begin
                        cnt        <= '0;
                        rem_q      <= '0;
                        divisor_q  <= mag2;
                        dvd_q      <= mag1;
                        neg_quot_q <= op1_neg ^ op2_neg;
                        neg_rem_q  <= op1_neg;
                    end
                end
                S_BY_ZERO: begin
                    rem_q <= '0;
                    dvd_q <= '0;
                end
                S_ON: begin
                    if (!annul_i) begin
                        cnt <= cnt + 1'b1;
                        // Sign fix-up is folded into the last iteration so END only copies out.
                        if (cnt == LAST_ITER) begin
                            rem_q <= rem_fix;
                            dvd_q <= quot_fix;
                        end else begin
                            rem_q <= rem_nxt;
                            dvd_q <= quot_nxt;
                        end
                    end
                end
                S_END: begin
                    if (annul_i || !start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else begin
                        result_o <= {rem_q, dvd_q};
                        ready_o  <= 1'b1;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for div_ctrl: driver pushes reference results, a negedge monitor pops on ready_o.
module tb_div_ctrl;

    localparam int WIDTH = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               stallreq_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] cur_exp = '0;
    logic        prev_rdy = 1'b0;

    div_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: integer division on magnitudes, then the quotient takes the XOR of signs
    // and the remainder takes the dividend's sign; divide-by-zero yields all zeros.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint ma, mb, q, r;
        logic   na, nb;
        if (b == 32'd0) return 64'd0;
        na = sgn && a[31];
        nb = sgn && b[31];
        ma = na ? (64'sh1_0000_0000 - longint'(a)) : longint'(a);
        mb = nb ? (64'sh1_0000_0000 - longint'(b)) : longint'(b);
        q  = ma / mb;
        r  = ma % mb;
        if (na ^ nb) q = -q;
        if (na)      r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: compare on ready_o rising, then hold value while high, zero while low.
    initial begin
        forever begin
            @(negedge clk);
            if (ready_o && !prev_rdy) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ready: got result %h with no request pending", result_o);
                end else begin
                    cur_exp = exp_q.pop_front();
                    check("result", result_o, cur_exp);
                end
            end else if (ready_o) begin
                check("result_hold", result_o, cur_exp);
            end else begin
                check("result_idle_zero", result_o, 64'd0);
            end
            prev_rdy = ready_o;
        end
    end

    // mode: 0 normal, 1 annul mid-ON, 2 async reset mid-ON, 3 async reset while in END
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int mode);
        int  t0;
        int  exp_lat;
        bit  got;
        bit  saw;
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        if (mode == 0 || mode == 3) exp_q.push_back(ref_div(a, b, sgn));
        exp_lat = (b == 32'd0) ? 2 : WIDTH + 1;
        t0  = cyc;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (ready_o) begin
                got = 1'b1;
                break;
            end
            check("stallreq_busy", {63'd0, stallreq_o}, 64'd1);
            if (mode == 1 && k == 11) begin
                annul_i = 1'b1;
                #1;
                check("stallreq_annul", {63'd0, stallreq_o}, 64'd0);
                @(negedge clk);
                annul_i = 1'b0;
                start_i = 1'b0;
                saw = 1'b0;
                for (int j = 0; j < 40; j++) begin
                    @(negedge clk);
                    if (ready_o) saw = 1'b1;
                end
                check("no_ready_after_annul", {63'd0, saw}, 64'd0);
                return;
            end
            if (mode == 2 && k == 6) begin
                #2;
                rst = 1'b0;
                #1;
                check("rst_mid_on_ready", {63'd0, ready_o}, 64'd0);
                check("rst_mid_on_result", result_o, 64'd0);
                start_i = 1'b0;
                #1;
                check("rst_stallreq", {63'd0, stallreq_o}, 64'd0);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            @(negedge clk);
            opdata1_i    = $urandom();
            opdata2_i    = $urandom();
            signed_div_i = 1'($urandom_range(0, 1));
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: ready_o still 0 after 60 cycles, op %h/%h", a, b);
            start_i = 1'b0;
            return;
        end
        check("latency", 64'(cyc - t0 - 1), 64'(exp_lat));
        check("stallreq_done", {63'd0, stallreq_o}, 64'd0);
        if (mode == 3) begin
            #2;
            rst = 1'b0;
            #1;
            check("rst_in_end_ready", {63'd0, ready_o}, 64'd0);
            check("rst_in_end_result", result_o, 64'd0);
            start_i = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            return;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        #1;
        check("ready_drop", {63'd0, ready_o}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        rst          = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        #3;
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        check("reset_stallreq", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op(32'd100,        32'd7,          1'b0, 0);
        run_op(32'hFFFF_FFF9,  32'h2,          1'b1, 0);
        run_op(32'd5,          32'd0,          1'b0, 0);
        run_op(32'hFFFF_FFFF,  32'd3,          1'b0, 1);
        run_op(32'd9,          32'd3,          1'b0, 0);
        run_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 0);
        run_op(32'd1000,       32'd7,          1'b0, 2);
        run_op(32'd12345,      32'hFFFF_FFB3,  1'b1, 0);
        run_op(32'd50,         32'd5,          1'b0, 3);
        run_op(32'd7,          32'hFFFF_FFFE,  1'b1, 0);
        run_op(32'hFFFF_FFF0,  32'd0,          1'b1, 0);
        run_op(32'hFFFF_FFFF,  32'd1,          1'b0, 0);
        run_op(32'd3,          32'd10,         1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom();
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = $urandom_range(1, 20);
                3:       rb = -$urandom_range(1, 20);
                default: rb = $urandom();
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), 0);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
